// File: rtl/csi_rx_pkg.sv
// Shared CSI-2 receive definitions: data-type codes, packet handler states
// and the 6-bit header ECC used by the optional header check.
package csi_rx_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;
    localparam logic [5:0] LONG_DT_MIN = 6'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE,
        ST_WAIT_LP
    } state_t;

    // CSI-2 Hamming parity over the 24 header bits (VC/DT, word count).
    function automatic logic [5:0] csi_hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
             ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
             ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
             ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
             ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
             ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// Header ECC checker: computes the expected ECC of the incoming header word and
// registers the match flag alongside the latched header.
module csi_rx_hdr_ecc
    import csi_rx_pkg::*;
(
    input  logic        clock,
    input  logic        areset,
    input  logic [29:0] hdr,
    input  logic        load,
    output logic        match
);

    logic [5:0] ecc_calc;

    always_comb begin
        ecc_calc = csi_hdr_ecc(hdr[23:0]);
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            match <= 1'b0;
        end else if (load) begin
            match <= (ecc_calc == hdr[29:24]);
        end
    end

endmodule

// File: rtl/csi_rx_vc_packet_handler.sv
// Multi-VC CSI-2 packet handler: header parse, per-VC frame/line tracking,
// payload forwarding with CRC stripping. Optional header ECC via CSI_RX_HDR_ECC_EN.
module csi_rx_vc_packet_handler
    import csi_rx_pkg::*;
#(
    parameter int unsigned NUM_VC       = 4,
    parameter logic [3:0]  VC_MASK      = 4'b1111,
    parameter logic [5:0]  FS_DT        = 6'h00,
    parameter logic [5:0]  FE_DT        = 6'h01,
    parameter logic [5:0]  VIDEO_DT     = 6'h2A,
    parameter logic        FWD_ALL_LONG = 1'b0,
    parameter logic [15:0] MAX_LEN      = 16'd8192
) (
    input  logic              clock,
    input  logic              areset,
    input  logic [31:0]       data,
    input  logic              data_enable,
    input  logic              data_frame,
    input  logic              lp_detect,
    output logic              sync_wait,
    output logic              packet_done,
    output logic [31:0]       payload,
    output logic              payload_enable,
    output logic              payload_frame,
    output logic [1:0]        payload_vc,
    output logic [5:0]        payload_dt,
    output logic [2:0]        payload_bytes,
    output logic [NUM_VC-1:0] vsync,
    output logic [NUM_VC-1:0] in_frame,
    output logic [NUM_VC-1:0] in_line,
    output logic [15:0]       hdr_err_count
);

    state_t state, state_next;

    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic [16:0] rem_q, consumed_q;
    logic [15:0] words_q;

    logic        hdr_load, is_long, vc_ok, accepted, ecc_bad, fwd, in_body, take, emit, timeout;
    logic        short_upd, err_inc, line_clear;
    logic [16:0] rem_cur, rem_next, consumed_cur, consumed_next, left;
    logic [15:0] words_cur, words_next;
    logic [2:0]  bytes;
    logic [NUM_VC-1:0] vc_sel;

    assign hdr_load = (state == ST_IDLE) && data_enable && data_frame;
    assign is_long  = (hdr_dt >= LONG_DT_MIN);
    assign vc_ok    = ({30'd0, hdr_vc} < NUM_VC);
    assign accepted = vc_ok && VC_MASK[hdr_vc];
    assign vc_sel   = NUM_VC'(4'b0001 << hdr_vc);

`ifdef CSI_RX_HDR_ECC_EN
    logic ecc_match;

    csi_rx_hdr_ecc u_hdr_ecc (
        .clock  (clock),
        .areset (areset),
        .hdr    (data[29:0]),
        .load   (hdr_load),
        .match  (ecc_match)
    );

    assign ecc_bad = !ecc_match;
`else
    assign ecc_bad = 1'b0;
`endif

    assign fwd = accepted && !ecc_bad && is_long && (FWD_ALL_LONG || hdr_dt == VIDEO_DT);

    // The word arriving during HDR is already the first body word, so HDR seeds
    // the counters directly instead of spending a cycle loading them.
    always_comb begin
        in_body       = (state == ST_PAYLOAD) || (state == ST_HDR && is_long && !ecc_bad);
        rem_cur       = (state == ST_HDR) ? {1'b0, hdr_wc} + 17'd2 : rem_q;
        consumed_cur  = (state == ST_HDR) ? '0 : consumed_q;
        words_cur     = (state == ST_HDR) ? '0 : words_q;
        take          = in_body && data_enable && data_frame && !lp_detect;
        rem_next      = rem_cur;
        consumed_next = consumed_cur;
        words_next    = words_cur;
        if (take) begin
            rem_next      = (rem_cur > 17'd4) ? rem_cur - 17'd4 : '0;
            consumed_next = consumed_cur + 17'd4;
            words_next    = words_cur + 16'd1;
        end
        left    = {1'b0, hdr_wc} - consumed_cur;
        bytes   = (left >= 17'd4) ? 3'd4 : left[2:0];
        emit    = take && fwd && (consumed_cur < {1'b0, hdr_wc});
        timeout = take && (words_next >= MAX_LEN);
    end

    assign short_upd  = (state == ST_HDR) && !lp_detect && !is_long && accepted && !ecc_bad;
    assign err_inc    = (state == ST_HDR) && !lp_detect && (ecc_bad || !vc_ok);
    assign line_clear = (state == ST_DONE) || (state != ST_IDLE && lp_detect);

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        sync_wait   = 1'b0;
        packet_done = 1'b0;
        case (state)
            ST_IDLE: begin
                sync_wait = 1'b1;
                if (hdr_load) state_next = ST_HDR;
            end
            ST_HDR, ST_PAYLOAD: begin
                if (lp_detect)                              state_next = ST_IDLE;
                else if (!in_body)                          state_next = ST_DONE;
                else if (!data_frame)                       state_next = ST_DONE;
                else if (take && (rem_next == '0 || timeout)) state_next = ST_DONE;
                else                                        state_next = ST_PAYLOAD;
            end
            ST_DONE: begin
                packet_done = 1'b1;
                state_next  = lp_detect ? ST_IDLE : ST_WAIT_LP;
            end
            ST_WAIT_LP: begin
                sync_wait = 1'b1;
                if (lp_detect) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            hdr_vc         <= '0;
            hdr_dt         <= '0;
            hdr_wc         <= '0;
            rem_q          <= '0;
            consumed_q     <= '0;
            words_q        <= '0;
            payload        <= '0;
            payload_enable <= 1'b0;
            payload_frame  <= 1'b0;
            payload_vc     <= '0;
            payload_dt     <= '0;
            payload_bytes  <= '0;
            vsync          <= '0;
            in_frame       <= '0;
            in_line        <= '0;
            hdr_err_count  <= '0;
        end else begin
            rem_q          <= rem_next;
            consumed_q     <= consumed_next;
            words_q        <= words_next;
            payload_enable <= emit;
            // Frame stays open across idle gaps until the last payload byte is out.
            payload_frame  <= emit || (payload_frame && state_next == ST_PAYLOAD
                                       && consumed_next < {1'b0, hdr_wc});
            vsync          <= '0;
            if (hdr_load) begin
                hdr_vc <= data[7:6];
                hdr_dt <= data[5:0];
                hdr_wc <= data[23:8];
            end
            if (emit) begin
                payload       <= data;
                payload_vc    <= hdr_vc;
                payload_dt    <= hdr_dt;
                payload_bytes <= bytes;
            end
            if (err_inc && hdr_err_count != '1) hdr_err_count <= hdr_err_count + 16'd1;
            if (short_upd && hdr_dt == FS_DT) begin
                vsync    <= vc_sel;
                in_frame <= in_frame | vc_sel;
            end
            if (short_upd && hdr_dt == FE_DT) begin
                in_frame <= in_frame & ~vc_sel;
                in_line  <= in_line & ~vc_sel;
            end
            if (emit && hdr_dt == VIDEO_DT) in_line <= in_line | vc_sel;
            if (line_clear) in_line <= '0;
        end
    end

endmodule

// File: tb/tb_csi_rx_vc_packet_handler.sv
// Self-checking bench for csi_rx_vc_packet_handler: directed and random packets
// compared against a packet-level reference model.
module tb_csi_rx_vc_packet_handler;

    localparam int unsigned NV   = 3;
    localparam logic [3:0]  MASK = 4'b0011;
    localparam int          MAXW = 16;

    logic          clock = 1'b0;
    logic          areset;
    logic [31:0]   data;
    logic          data_enable, data_frame, lp_detect;
    logic          sync_wait, packet_done, payload_enable, payload_frame;
    logic [31:0]   payload;
    logic [1:0]    payload_vc;
    logic [5:0]    payload_dt;
    logic [2:0]    payload_bytes;
    logic [NV-1:0] vsync, in_frame, in_line;
    logic [15:0]   hdr_err_count;

    int checks = 0;
    int errors = 0;
    logic [NV-1:0] mf = '0;
    int merr = 0;

    csi_rx_vc_packet_handler #(
        .NUM_VC  (NV),
        .VC_MASK (MASK),
        .MAX_LEN (16'd16)
    ) dut (
        .clock          (clock),
        .areset         (areset),
        .data           (data),
        .data_enable    (data_enable),
        .data_frame     (data_frame),
        .lp_detect      (lp_detect),
        .sync_wait      (sync_wait),
        .packet_done    (packet_done),
        .payload        (payload),
        .payload_enable (payload_enable),
        .payload_frame  (payload_frame),
        .payload_vc     (payload_vc),
        .payload_dt     (payload_dt),
        .payload_bytes  (payload_bytes),
        .vsync          (vsync),
        .in_frame       (in_frame),
        .in_line        (in_line),
        .hdr_err_count  (hdr_err_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef CSI_RX_HDR_ECC_EN
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] col [0:23];
        logic [5:0] e;
        col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
        return e;
    endfunction
`endif

    // One complete packet: header, body words, then the LP return to IDLE.
    task automatic run_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                              input bit gaps, input int drop_at, input bit bad_ecc);
        bit acc, lng, rej, fwd, dropped;
        int need, k, rem_b;
        logic [31:0] w;
        logic [5:0] ecc6;
        logic [2:0] vs_exp;
        acc = (vc < NV) && MASK[vc];
        lng = (dt >= 6'h10);
`ifdef CSI_RX_HDR_ECC_EN
        rej  = bad_ecc;
        ecc6 = ref_ecc({wc, vc, dt}) ^ (bad_ecc ? 6'(1 << $urandom_range(0, 5)) : 6'h00);
`else
        rej  = 1'b0;
        ecc6 = 6'($urandom);
`endif
        fwd  = acc && lng && !rej && (dt == 6'h2A);
        need = (int'(wc) + 2 + 3) / 4;
        k    = (need < MAXW) ? need : MAXW;
        dropped = (drop_at > 0) && (drop_at < k);
        if (dropped) k = drop_at;
        if (vc >= NV || rej) merr++;
        vs_exp = '0;
        if (acc && !lng && !rej) begin
            if (dt == 6'h00) begin
                vs_exp = 3'b001 << vc;
                mf = mf | vs_exp;
            end
            if (dt == 6'h01) mf = mf & ~(3'b001 << vc);
        end

        data = {2'b00, ecc6, wc, vc, dt};
        data_enable = 1'b1;
        data_frame = 1'b1;
        tick();
        check("hdr_sync_wait", sync_wait, 0);

        if (!lng || rej) begin
            data = $urandom;
            data_enable = 1'b0;
            data_frame = 1'b0;
            tick();
            check("short_vsync", vsync, vs_exp);
            check("short_in_frame", in_frame, mf);
            check("short_no_payload", payload_enable, 0);
        end else begin
            for (int i = 0; i < k; i++) begin
                rem_b = int'(wc) - 4 * i;
                if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                    data = $urandom;
                    data_enable = 1'b0;
                    tick();
                    check("gap_no_payload", payload_enable, 0);
                    if (fwd && rem_b > 0) check("gap_frame_held", payload_frame, 1);
                end
                w = $urandom;
                data = w;
                data_enable = 1'b1;
                tick();
                if (fwd && rem_b > 0) begin
                    check("pl_enable", payload_enable, 1);
                    check("pl_data", payload, w);
                    check("pl_bytes", payload_bytes, (rem_b >= 4) ? 4 : rem_b);
                    check("pl_vc_dt", {payload_vc, payload_dt}, {vc, dt});
                    check("pl_frame", payload_frame, 1);
                    check("pl_in_line", in_line, 3'b001 << vc);
                end else begin
                    check("crc_or_drop_word", payload_enable, 0);
                end
            end
            if (dropped) begin
                data_enable = 1'b0;
                data_frame = 1'b0;
                tick();
                check("drop_frame_low", payload_frame, 0);
            end
        end
        check("packet_done", packet_done, 1);

        data_enable = 1'b0;
        data_frame = 1'b0;
        tick();
        check("done_one_cycle", packet_done, 0);
        check("wait_sync", sync_wait, 1);
        check("tail_frame", payload_frame, 0);
        check("tail_in_line", in_line, 0);
        check("tail_in_frame", in_frame, mf);
        check("hdr_err_count", hdr_err_count, merr);
        lp_detect = 1'b1;
        tick();
        lp_detect = 1'b0;
        tick();
        check("idle_sync", sync_wait, 1);
    endtask

    logic [5:0] dts [0:5];

    initial begin
        dts = '{6'h00, 6'h01, 6'h02, 6'h2A, 6'h2B, 6'h12};
        areset = 1'b1;
        data = '0;
        data_enable = 1'b0;
        data_frame = 1'b0;
        lp_detect = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("rst_sync_wait", sync_wait, 1);
        check("rst_outputs", {packet_done, payload_enable, payload_frame, vsync, in_frame, in_line}, 0);
        check("rst_err", hdr_err_count, 0);

        run_packet(2'd1, 6'h00, 16'h0001, 0, 0, 0);   // FS on VC1
        run_packet(2'd0, 6'h2A, 16'd8, 0, 0, 0);      // two full payload words + CRC word
        run_packet(2'd0, 6'h2A, 16'd5, 1, 0, 0);      // 4 then 1 byte
        run_packet(2'd2, 6'h2A, 16'd8, 0, 0, 0);      // masked VC
        run_packet(2'd2, 6'h00, 16'd0, 0, 0, 0);
        run_packet(2'd3, 6'h2A, 16'd12, 0, 0, 0);     // out-of-range VC
        run_packet(2'd1, 6'h2A, 16'hFFFF, 0, 0, 0);   // timeout
        run_packet(2'd0, 6'h2A, 16'd40, 0, 3, 0);     // data_frame drop
        run_packet(2'd1, 6'h2A, 16'd0, 0, 0, 0);      // CRC only
        run_packet(2'd1, 6'h01, 16'h0001, 0, 0, 0);   // FE on VC1

        // LP entry mid-payload: back to IDLE without packet_done.
        data = 32'h0028_002A;
        data_enable = 1'b1;
        data_frame = 1'b1;
        tick();
        data = $urandom;
        tick();
        data = $urandom;
        tick();
        data_enable = 1'b0;
        lp_detect = 1'b1;
        tick();
        check("lp_abort_no_done", packet_done, 0);
        check("lp_abort_sync", sync_wait, 1);
        check("lp_abort_line", in_line, 0);
        check("lp_abort_frame", payload_frame, 0);
        lp_detect = 1'b0;
        data_frame = 1'b0;
        tick();
        check("lp_abort_idle", {sync_wait, packet_done}, 2'b10);

`ifdef CSI_RX_HDR_ECC_EN
        run_packet(2'd0, 6'h2A, 16'd8, 0, 0, 1);      // wrong ECC rejected
        run_packet(2'd0, 6'h2A, 16'd8, 0, 0, 0);
        run_packet(2'd1, 6'h00, 16'd3, 0, 0, 1);
`endif

        for (int n = 0; n < 40; n++) begin
            run_packet(2'($urandom_range(0, 3)), dts[$urandom_range(0, 5)],
                       16'($urandom_range(0, 70)), bit'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0,
                       ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
